// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the 16-bit, 3-bit-opcode CPU: PC, instruction latch, decode and
// register-file / ALU / data-memory steering. Optional HALT_ON_SELF_JUMP_EN: self-jump halts.
module cpu_control_unit #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned DADDR_W  = 10,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    input  logic [15:0]        instr,
    input  logic               alu_neg,
    input  logic               mem_ack,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         rf_ra,
    output logic [2:0]         rf_rb,
    output logic [2:0]         rf_wa,
    output logic               rf_we,
    output logic               rf_wsel,
    output logic [1:0]         alu_op,
    output logic [DADDR_W-1:0] mem_addr,
    output logic               mem_req,
    output logic               mem_we,
    output logic               halted,
    output logic               fault
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned IR_W   = 16;

    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_JUMP  = 3'b110;
    localparam logic [2:0] OP_BLT   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic                lt_flag_q, lt_flag_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [2:0]          rf_ra_q, rf_ra_d, rf_rb_q, rf_rb_d, rf_wa_q, rf_wa_d;
    logic                rf_we_q, rf_we_d, rf_wsel_q, rf_wsel_d;
    logic [1:0]          alu_op_q, alu_op_d;
    logic [DADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic                halted_q, halted_d, fault_q, fault_d;

    logic [2:0]          opcode;
    logic [PC_W-1:0]     jmp_tgt;
    logic [PC_W-1:0]     pc_inc;
    logic                load_ack;

    assign opcode  = ir_q[15:13];
    assign jmp_tgt = ir_q[PC_W-1:0];
    assign pc_inc  = pc_q + PC_W'(1);

    // Load data is only valid while mem_ack is high, so the write strobe follows it directly.
    assign load_ack = (state_q == S_MEM) && mem_req_q && !mem_we_q && mem_ack;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        lt_flag_d  = lt_flag_q;
        wait_cnt_d = wait_cnt_q;
        rf_ra_d    = rf_ra_q;
        rf_rb_d    = rf_rb_q;
        rf_wa_d    = rf_wa_q;
        rf_we_d    = 1'b0;
        rf_wsel_d  = rf_wsel_q;
        alu_op_d   = alu_op_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = 1'b0;
        mem_we_d   = mem_we_q;
        fault_d    = fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = start_pc;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                rf_ra_d    = ir_q[9:7];
                rf_rb_d    = ir_q[6:4];
                rf_wa_d    = ir_q[12:10];
                alu_op_d   = ir_q[14:13];
                mem_addr_d = DADDR_W'(ir_q[9:0]);
                mem_we_d   = (opcode == OP_STORE);
                rf_wsel_d  = 1'b0;
                rf_we_d    = !opcode[2];
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                unique case (opcode)
                    OP_LOAD, OP_STORE: begin
                        mem_req_d  = 1'b1;
                        rf_ra_d    = ir_q[12:10];
                        rf_wsel_d  = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = S_MEM;
                    end
                    OP_JUMP: begin
                        pc_d = jmp_tgt;
`ifdef HALT_ON_SELF_JUMP_EN
                        state_d = (jmp_tgt == pc_q) ? S_HALT : S_FETCH;
`else
                        state_d = S_FETCH;
`endif
                    end
                    OP_BLT: begin
                        pc_d    = lt_flag_q ? jmp_tgt : pc_inc;
                        state_d = S_FETCH;
                    end
                    default: begin
                        lt_flag_d = alu_neg;
                        pc_d      = pc_inc;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    pc_d       = pc_inc;
                    wait_cnt_d = '0;
                    state_d    = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_d      = start_pc;
                    fault_d   = 1'b0;
                    lt_flag_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            lt_flag_q  <= 1'b0;
            wait_cnt_q <= '0;
            rf_ra_q    <= '0;
            rf_rb_q    <= '0;
            rf_wa_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_wsel_q  <= 1'b0;
            alu_op_q   <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            lt_flag_q  <= lt_flag_d;
            wait_cnt_q <= wait_cnt_d;
            rf_ra_q    <= rf_ra_d;
            rf_rb_q    <= rf_rb_d;
            rf_wa_q    <= rf_wa_d;
            rf_we_q    <= rf_we_d;
            rf_wsel_q  <= rf_wsel_d;
            alu_op_q   <= alu_op_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign pc       = pc_q;
    assign rf_ra    = rf_ra_q;
    assign rf_rb    = rf_rb_q;
    assign rf_wa    = rf_wa_q;
    assign rf_we    = rf_we_q | load_ack;
    assign rf_wsel  = rf_wsel_q;
    assign alu_op   = alu_op_q;
    assign mem_addr = mem_addr_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign halted   = halted_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with ROM, data memory, register file and ALU models.
module tb_cpu_control_unit;

`ifdef HALT_ON_SELF_JUMP_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic [15:0] instr;
    logic        alu_neg;
    logic        mem_ack = 1'b0;
    logic [7:0]  pc;
    logic [2:0]  rf_ra, rf_rb, rf_wa;
    logic        rf_we, rf_wsel, mem_req, mem_we, halted, fault;
    logic [1:0]  alu_op;
    logic [9:0]  mem_addr;

    logic [15:0] rom [0:255];
    logic [15:0] dmem [0:1023];
    logic [15:0] rf [0:7];
    logic [15:0] rf_init [0:7];
    logic [15:0] op_a, op_b, alu_res;
    logic [9:0]  st_addr;
    logic [15:0] st_data;
    logic [2:0]  st_ra;
    int          st_cnt;

    bit ack_auto = 1'b0;
    int ack_req = 0;
    int ack_given = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cpu_control_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .instr(instr),
        .alu_neg(alu_neg), .mem_ack(mem_ack), .pc(pc), .rf_ra(rf_ra), .rf_rb(rf_rb),
        .rf_wa(rf_wa), .rf_we(rf_we), .rf_wsel(rf_wsel), .alu_op(alu_op),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
        .fault(fault)
    );

    assign instr   = rom[pc];
    assign op_a    = rf[rf_ra];
    assign op_b    = rf[rf_rb];
    assign alu_neg = alu_res[15];

    always_comb begin
        case (alu_op)
            2'b00:   alu_res = op_a & op_b;
            2'b01:   alu_res = op_a | op_b;
            2'b10:   alu_res = op_a + op_b;
            default: alu_res = op_a - op_b;
        endcase
    end

    // Register file and store log.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
            st_addr <= '0;
            st_data <= '0;
            st_ra   <= '0;
            st_cnt  <= 0;
        end else begin
            if (rf_we) rf[rf_wa] <= rf_wsel ? dmem[mem_addr] : alu_res;
            if (mem_req && mem_ack && mem_we) begin
                st_addr <= mem_addr;
                st_data <= rf[rf_ra];
                st_ra   <= rf_ra;
                st_cnt  <= st_cnt + 1;
            end
        end
    end

    // Memory responder: one-cycle ack on the negedge, automatic or on request.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ack) mem_ack = 1'b0;
            else if ((mem_req && ack_auto) || (ack_given < ack_req)) begin
                mem_ack = 1'b1;
                if (ack_given < ack_req) ack_given++;
            end
        end
    end

    function automatic logic [15:0] i_alu(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] i_mem(input logic [2:0] op, input logic [2:0] r,
                                          input logic [9:0] a);
        return {op, r, a};
    endfunction

    function automatic logic [15:0] i_jmp(input logic [2:0] op, input logic [7:0] t);
        return {op, 5'b00000, t};
    endfunction

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic prep;
        for (int i = 0; i < 256; i++) rom[i] = i_jmp(3'b110, 8'(i));
        for (int i = 0; i < 8; i++) rf_init[i] = '0;
        ack_auto = 1'b1;
    endtask

    task automatic do_reset;
        start = 1'b0;
        rst_n = 1'b0;
        step;
        step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic pulse_start(input logic [7:0] a);
        start_pc = a;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic test_reset;
        prep;
        do_reset;
        total++; if (pc !== 8'd0) begin bad++; $display("FAIL rst_pc got=%0d want=0", pc); end
        total++; if ({halted, fault, rf_we, mem_req, mem_we} !== 5'b0) begin
            bad++; $display("FAIL rst_flags got=%b want=00000", {halted, fault, rf_we, mem_req, mem_we}); end
        repeat (4) step;
        total++; if ({pc, mem_req, rf_we} !== 10'd0) begin
            bad++; $display("FAIL idle_hold got pc=%0d req=%b we=%b want 0", pc, mem_req, rf_we); end
    endtask

    task automatic test_alu_latency;
        prep;
        rom[20] = i_alu(3'b010, 3'd4, 3'd1, 3'd2);
        rf_init[1] = 16'h0011;
        rf_init[2] = 16'h0022;
        do_reset;
        pulse_start(8'd20);
        step;
        step;
        total++; if ({rf_we, rf_wsel, rf_wa, rf_ra, rf_rb, alu_op, pc} !== {1'b1, 1'b0, 3'd4, 3'd1, 3'd2, 2'b10, 8'd20}) begin
            bad++; $display("FAIL alu_exec got we=%b ws=%b wa=%0d ra=%0d rb=%0d op=%b pc=%0d want 1 0 4 1 2 10 20",
                rf_we, rf_wsel, rf_wa, rf_ra, rf_rb, alu_op, pc); end
        step;
        total++; if ({rf_we, pc} !== {1'b0, 8'd21}) begin
            bad++; $display("FAIL alu_next got we=%b pc=%0d want 0 21", rf_we, pc); end
        total++; if (rf[4] !== 16'h0033) begin bad++; $display("FAIL alu_result got=%h want=0033", rf[4]); end
    endtask

    task automatic test_load_latency;
        prep;
        ack_auto = 1'b0;
        rom[30] = i_mem(3'b100, 3'd5, 10'd7);
        dmem[7] = 16'hBEEF;
        do_reset;
        pulse_start(8'd30);
        step;
        step;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ld_exec_req got=%b want=0", mem_req); end
        step;
        total++; if ({mem_req, mem_we, mem_addr, rf_we, rf_ra} !== {1'b1, 1'b0, 10'd7, 1'b0, 3'd5}) begin
            bad++; $display("FAIL ld_mem got req=%b we=%b addr=%0d rfwe=%b ra=%0d want 1 0 7 0 5",
                mem_req, mem_we, mem_addr, rf_we, rf_ra); end
        ack_req++;
        step;
        total++; if ({mem_ack, rf_we, rf_wsel, rf_wa, mem_req, pc} !== {1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 8'd30}) begin
            bad++; $display("FAIL ld_ack got ack=%b we=%b ws=%b wa=%0d req=%b pc=%0d want 1 1 1 5 1 30",
                mem_ack, rf_we, rf_wsel, rf_wa, mem_req, pc); end
        step;
        total++; if ({mem_req, rf_we, pc} !== {1'b0, 1'b0, 8'd31}) begin
            bad++; $display("FAIL ld_done got req=%b we=%b pc=%0d want 0 0 31", mem_req, rf_we, pc); end
        total++; if (rf[5] !== 16'hBEEF) begin bad++; $display("FAIL ld_data got=%h want=beef", rf[5]); end
    endtask

    task automatic test_program(input logic [7:0] base, input logic [2:0] alu, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] exp);
        prep;
        rom[base]      = i_mem(3'b100, 3'd1, 10'd0);
        rom[base + 1]  = i_mem(3'b100, 3'd2, 10'd1);
        rom[base + 2]  = i_alu(alu, 3'd3, 3'd1, 3'd2);
        rom[base + 3]  = i_mem(3'b101, 3'd3, 10'd100);
        dmem[0] = a;
        dmem[1] = b;
        do_reset;
        pulse_start(base);
        repeat (40) step;
        total++; if (rf[3] !== exp) begin bad++; $display("FAIL prog%0d_r3 got=%h want=%h", base, rf[3], exp); end
        total++; if ({st_cnt[7:0], st_addr, st_ra, st_data} !== {8'd1, 10'd100, 3'd3, exp}) begin
            bad++; $display("FAIL prog%0d_store got cnt=%0d addr=%0d ra=%0d data=%h want 1 100 3 %h",
                base, st_cnt, st_addr, st_ra, st_data, exp); end
        total++; if ({pc, halted, fault} !== {8'(base + 4), EN, 1'b0}) begin
            bad++; $display("FAIL prog%0d_end got pc=%0d halted=%b fault=%b want %0d %b 0",
                base, pc, halted, fault, base + 4, EN); end
    endtask

    task automatic test_blt(input logic [15:0] a, input logic [15:0] b, input logic [7:0] exp_pc,
                            input logic [15:0] exp_st);
        prep;
        rom[10] = i_mem(3'b100, 3'd1, 10'd0);
        rom[11] = i_mem(3'b100, 3'd2, 10'd1);
        rom[12] = i_alu(3'b011, 3'd0, 3'd1, 3'd2);
        rom[13] = i_jmp(3'b111, 8'd16);
        rom[14] = i_mem(3'b101, 3'd1, 10'd100);
        rom[16] = i_mem(3'b101, 3'd2, 10'd100);
        dmem[0] = a;
        dmem[1] = b;
        do_reset;
        pulse_start(8'd10);
        repeat (40) step;
        total++; if ({st_cnt[7:0], st_data} !== {8'd1, exp_st}) begin
            bad++; $display("FAIL blt_store got cnt=%0d data=%h want 1 %h", st_cnt, st_data, exp_st); end
        total++; if ({pc, halted} !== {exp_pc, EN}) begin
            bad++; $display("FAIL blt_pc got pc=%0d halted=%b want %0d %b", pc, halted, exp_pc, EN); end
    endtask

    task automatic test_fault;
        int  n;
        bit  we_seen;
        n = 0;
        we_seen = 1'b0;
        prep;
        ack_auto = 1'b0;
        rom[40] = i_mem(3'b100, 3'd1, 10'd2);
        do_reset;
        pulse_start(8'd40);
        for (int i = 0; i < 40; i++) begin
            step;
            if (mem_req) n++;
            if (rf_we) we_seen = 1'b1;
            if (halted) break;
        end
        total++; if (n !== 15) begin bad++; $display("FAIL fault_wait got=%0d want=15", n); end
        total++; if ({fault, halted, mem_req, we_seen} !== 4'b1100) begin
            bad++; $display("FAIL fault_state got f=%b h=%b req=%b we=%b want 1 1 0 0", fault, halted, mem_req, we_seen); end
        ack_req++;
        step;
        step;
        total++; if ({halted, fault, pc, rf_we} !== {1'b1, 1'b1, 8'd40, 1'b0}) begin
            bad++; $display("FAIL stray_ack got h=%b f=%b pc=%0d we=%b want 1 1 40 0", halted, fault, pc, rf_we); end
        pulse_start(8'd20);
        total++; if ({fault, halted, pc} !== {1'b0, 1'b0, 8'd20}) begin
            bad++; $display("FAIL fault_clear got f=%b h=%b pc=%0d want 0 0 20", fault, halted, pc); end
    endtask

    task automatic test_wrap;
        bit saw;
        saw = 1'b0;
        prep;
        rom[50]  = i_jmp(3'b110, 8'd255);
        rom[255] = i_alu(3'b000, 3'd0, 3'd0, 3'd0);
        do_reset;
        pulse_start(8'd50);
        for (int i = 0; i < 30; i++) begin
            step;
            if (pc == 8'd255) saw = 1'b1;
        end
        total++; if ({saw, pc, halted} !== {1'b1, 8'd0, EN}) begin
            bad++; $display("FAIL wrap got saw255=%b pc=%0d halted=%b want 1 0 %b", saw, pc, halted, EN); end
    endtask

    task automatic test_self_jump;
        bit strobe;
        strobe = 1'b0;
        prep;
        do_reset;
        pulse_start(8'd4);
        step;
        pulse_start(8'd77);
        for (int i = 0; i < 20; i++) begin
            step;
            if (rf_we || mem_req) strobe = 1'b1;
        end
        total++; if ({pc, halted, strobe} !== {8'd4, EN, 1'b0}) begin
            bad++; $display("FAIL self_jump got pc=%0d halted=%b strobe=%b want 4 %b 0", pc, halted, strobe, EN); end
    endtask

    task automatic test_reset_mid;
        bit got;
        got = 1'b0;
        prep;
        ack_auto = 1'b0;
        rom[40] = i_mem(3'b101, 3'd1, 10'd9);
        do_reset;
        pulse_start(8'd40);
        for (int i = 0; i < 10; i++) begin
            step;
            if (mem_req) begin got = 1'b1; break; end
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL mid_req got=%b want=1", got); end
        rst_n = 1'b0;
        #1;
        total++; if ({mem_req, mem_we, rf_we, halted, fault, pc} !== {5'b0, 8'd0}) begin
            bad++; $display("FAIL mid_reset got req=%b we=%b rfwe=%b h=%b f=%b pc=%0d want all 0",
                mem_req, mem_we, rf_we, halted, fault, pc); end
        step;
        rst_n = 1'b1;
        step;
    endtask

    initial begin
        test_reset;
        test_alu_latency;
        test_load_latency;
        test_program(8'd0, 3'b010, 16'd5, 16'd9, 16'd14);
        test_program(8'd5, 3'b011, 16'd3, 16'd7, 16'hFFFC);
        test_blt(16'd3, 16'd7, 8'd17, 16'd7);
        test_blt(16'd9, 16'd4, 8'd15, 16'd9);
        test_fault;
        test_wrap;
        test_self_jump;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
